// File: rtl/rr_mux_sel_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux select generator.
package rr_mux_sel_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Plain 4:1 bit multiplexer fed by rr_mux_sel's select.
module mux4to1 (
  input  logic [3:0] A,
  input  logic [1:0] S,
  output logic       Y
);

  assign Y = A[S];

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... mod 4.
module rr_pick4
  import rr_mux_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] last_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o
);

  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      // Index arithmetic wraps naturally modulo N_REQ at SEL_W bits.
      cand = SEL_W'(32'(last_i) + k);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rr_mux_sel.sv
// Round-robin select generator for mux4to1 with a max-hold timeout and registered sampling of Y.
module rr_mux_sel
  import rr_mux_sel_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  input  logic             y,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             valid,
  output logic             y_q,
  output logic             y_vld
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic             samp_q, samp_d;
  logic             svld_q, svld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             release_c;

  rr_pick4 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign release_c = ack || !req[sel_q] || (cnt_q == CNT_W'(HOLD_MAX - 1));

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    samp_d  = samp_q;
    svld_d  = svld_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        svld_d = 1'b0;
        if (pick_any) begin
          sel_d   = pick_idx;
          gnt_d   = onehot(pick_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        samp_d = y;
        svld_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        // sel is kept on release so the final sample and the idle mux path stay on the last grantee.
        if (release_c) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          last_d  = sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; last=3 gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      gnt_q   <= '0;
      valid_q <= 1'b0;
      samp_q  <= 1'b0;
      svld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      samp_q  <= samp_d;
      svld_q  <= svld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign y_q   = samp_q;
  assign y_vld = svld_q;

endmodule

// File: tb/tb_rr_mux_sel.sv
// Self-checking bench for rr_mux_sel driving a mux4to1: reference model scoreboard plus directed vectors.
module tb_rr_mux_sel;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] a;
  logic       y;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic       y_q;
  logic       y_vld;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       yq;
    logic       yvld;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] a;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       yq;
    logic       yvld;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[11];

  // Reference model state
  logic       m_grant;
  logic [1:0] m_sel;
  logic [3:0] m_gnt;
  logic       m_valid;
  logic       m_yq;
  logic       m_yvld;
  int         m_cnt;
  int         m_last;

  rr_mux_sel #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .ack   (ack),
    .y     (y),
    .sel   (sel),
    .gnt   (gnt),
    .valid (valid),
    .y_q   (y_q),
    .y_vld (y_vld)
  );

  mux4to1 u_mux (.A(a), .S(sel), .Y(y));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic [3:0] rq, input logic ak, input logic yv);
    int  idx;
    logic found;
    if (r) begin
      m_grant = 1'b0; m_sel = 2'd0; m_gnt = 4'd0; m_valid = 1'b0;
      m_yq = 1'b0; m_yvld = 1'b0; m_cnt = 0; m_last = 3;
    end else if (!m_grant) begin
      m_yvld = 1'b0;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (!found && rq[idx]) begin
          found   = 1'b1;
          m_sel   = 2'(idx);
          m_gnt   = 4'(1 << idx);
          m_valid = 1'b1;
          m_cnt   = 0;
          m_grant = 1'b1;
        end
      end
    end else begin
      m_yq   = yv;
      m_yvld = 1'b1;
      if (ak || !rq[m_sel] || m_cnt == HOLD - 1) begin
        m_gnt   = 4'd0;
        m_valid = 1'b0;
        m_last  = int'(m_sel);
        m_grant = 1'b0;
      end
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Drive one cycle, push the model's expectation, pop and compare after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic ak, input logic [3:0] av);
    exp_t e;
    rst = r; req = rq; ack = ak; a = av;
    model_step(r, rq, ak, av[m_sel]);
    e.gnt = m_gnt; e.sel = m_sel; e.valid = m_valid; e.yq = m_yq; e.yvld = m_yvld;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    checks++;
    if (gnt !== e.gnt || sel !== e.sel || valid !== e.valid || y_q !== e.yq || y_vld !== e.yvld) begin
      errors++;
      $display("FAIL model cyc=%0d got gnt=%b sel=%0d valid=%b y_q=%b y_vld=%b exp gnt=%b sel=%0d valid=%b y_q=%b y_vld=%b",
               cyc, gnt, sel, valid, y_q, y_vld, e.gnt, e.sel, e.valid, e.yq, e.yvld);
    end
  endtask

  initial begin
    logic [3:0] rot_exp [5];
    logic [3:0] seen [$];
    logic       vals [24];
    logic       prev_v;
    int         s, run, gap;

    rst = 1'b1; req = '0; ack = 1'b0; a = '0;

    // Directed vectors: reset/first grant, then sampling through the mux.
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0010, 1'b0, 4'b0101, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0010, 1'b0, 4'b0101, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'b0010, 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'b0010, 1'b1, 4'b1010, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 4'b1010, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].a);
      checks++;
      if (gnt !== tbl[i].gnt || sel !== tbl[i].sel || valid !== tbl[i].valid ||
          y_q !== tbl[i].yq || y_vld !== tbl[i].yvld) begin
        errors++;
        $display("FAIL vec%0d got gnt=%b sel=%0d valid=%b y_q=%b y_vld=%b exp gnt=%b sel=%0d valid=%b y_q=%b y_vld=%b",
                 i, gnt, sel, valid, y_q, y_vld, tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].yq, tbl[i].yvld);
      end
    end

    // Rotation: all requesting, ack during each grant cycle.
    rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;
    step(1'b1, 4'b1111, 1'b0, 4'b0000);
    prev_v = 1'b0;
    for (int i = 0; i < 40 && seen.size() < 5; i++) begin
      step(1'b0, 4'b1111, m_valid, 4'b0000);
      if (valid && prev_v) check_val("rot_gap", 1, 0);
      if (gnt != 4'b0000) seen.push_back(gnt);
      prev_v = valid;
    end
    check_val("rot_count", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      check_val($sformatf("rot_gnt%0d", i), int'(seen[i]), int'(rot_exp[i]));

    // Timeout: single requester held, never acked.
    step(1'b1, 4'b0000, 1'b0, 4'b0000);
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 4'b0100, 1'b0, 4'b1111);
      vals[i] = valid;
      if (valid) check_val("to_gnt", int'(gnt), 4);
    end
    s = 0;
    while (s < 24 && !vals[s]) s++;
    run = 0;
    while (s + run < 24 && vals[s + run]) run++;
    gap = 0;
    while (s + run + gap < 24 && !vals[s + run + gap]) gap++;
    check_val("to_first", s, 0);
    check_val("to_hold", run, HOLD);
    check_val("to_gap", gap, 1);
    check_val("to_regrant", (s + run + gap < 24) ? int'(vals[s + run + gap]) : 0, 1);

    // Simultaneous ack, timeout and req drop on requester 0.
    step(1'b1, 4'b0000, 1'b0, 4'b0000);
    step(1'b0, 4'b0001, 1'b0, 4'b0000);
    check_val("sim_gnt0", int'(gnt), 1);
    for (int i = 0; i < HOLD - 1; i++) step(1'b0, 4'b0001, 1'b0, 4'b0000);
    check_val("sim_held", int'(valid), 1);
    step(1'b0, 4'b1110, 1'b1, 4'b0000);
    check_val("sim_release", int'(valid), 0);
    step(1'b0, 4'b1110, 1'b0, 4'b0000);
    check_val("sim_next", int'(gnt), 2);

    // Reset in the middle of a grant to requester 3.
    step(1'b1, 4'b0000, 1'b0, 4'b0000);
    step(1'b0, 4'b1000, 1'b0, 4'b1000);
    step(1'b0, 4'b1000, 1'b0, 4'b1000);
    check_val("mid_gnt3", int'(gnt), 8);
    check_val("mid_yvld", int'(y_vld), 1);
    step(1'b1, 4'b1000, 1'b0, 4'b1000);
    check_val("mid_rst_gnt", int'(gnt), 0);
    check_val("mid_rst_yvld", int'(y_vld), 0);
    step(1'b0, 4'b1001, 1'b0, 4'b0000);
    check_val("mid_after", int'(gnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

endmodule
